// File: rtl/vend_pkg.sv
// Shared vending definitions: payout FSM state encodings and coin unit values.
// The credit-side FSM uses the same coin units.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_EJECT = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam int COIN5_UNITS  = 1;
  localparam int COIN10_UNITS = 2;

endpackage

// File: rtl/payout_timer.sv
// Loadable up-counter with clear and enable. term is high while the count equals
// LIMIT-1, and the count holds there.
module payout_timer #(
  parameter  int LIMIT = 4,
  localparam int W     = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic         term
);

  logic [W-1:0] cnt;

  assign term = (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (ld)         cnt <= ld_val;
    else if (en && !term) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/coin_payout_fsm.sv
// Change/refund dispenser driving 5- and 10-unit hoppers with a request/ack handshake.
// Define COIN_TALLY_EN to add saturating acknowledged-ejection tallies per coin type.
module coin_payout_fsm
  import vend_pkg::*;
#(
  parameter int AMT_W      = 4,
  parameter int TIMEOUT    = 1000,
  parameter int GAP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             hopper_ack,
  input  logic             empty5,
  input  logic             empty10,
  output logic             eject5,
  output logic             eject10,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [AMT_W-1:0] remaining,
`ifdef COIN_TALLY_EN
  output logic [7:0]       tally5,
  output logic [7:0]       tally10,
`endif
  output logic [2:0]       state
);

  state_t st;
  logic   coin10;
  logic   to_term, gap_term;

  // The timeout counter restarts on every EJECT entry; ack also clears it.
  payout_timer #(.LIMIT(TIMEOUT)) u_to_timer (
    .clk, .rst,
    .clr   (st != ST_EJECT || hopper_ack),
    .en    (st == ST_EJECT),
    .ld    (1'b0),
    .ld_val('0),
    .term  (to_term)
  );

  payout_timer #(.LIMIT(GAP_CYCLES)) u_gap_timer (
    .clk, .rst,
    .clr   (st != ST_GAP),
    .en    (st == ST_GAP),
    .ld    (1'b0),
    .ld_val('0),
    .term  (gap_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_IDLE;
      remaining <= '0;
      coin10    <= 1'b0;
`ifdef COIN_TALLY_EN
      tally5    <= '0;
      tally10   <= '0;
`endif
    end else begin
      case (st)
        ST_IDLE, ST_ERR: if (start) begin
          remaining <= amount;
          st        <= ST_SEL;
        end
        ST_SEL: begin
          if (remaining == '0)
            st <= ST_DONE;
          else if (remaining >= AMT_W'(COIN10_UNITS) && !empty10) begin
            coin10 <= 1'b1;
            st     <= ST_EJECT;
          end else if (!empty5) begin
            coin10 <= 1'b0;
            st     <= ST_EJECT;
          end else
            st <= ST_ERR;
        end
        ST_EJECT: begin
          // Ack takes priority over a simultaneous timeout expiry.
          if (hopper_ack) begin
            remaining <= remaining - (coin10 ? AMT_W'(COIN10_UNITS) : AMT_W'(COIN5_UNITS));
            st        <= ST_GAP;
`ifdef COIN_TALLY_EN
            if (coin10) begin
              if (tally10 != 8'hFF) tally10 <= tally10 + 8'd1;
            end else begin
              if (tally5 != 8'hFF) tally5 <= tally5 + 8'd1;
            end
`endif
          end else if (to_term)
            st <= ST_ERR;
        end
        ST_GAP:  if (gap_term) st <= ST_SEL;
        ST_DONE: st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign state   = st;
  assign eject10 = (st == ST_EJECT) &&  coin10;
  assign eject5  = (st == ST_EJECT) && !coin10;
  assign busy    = (st == ST_SEL) || (st == ST_EJECT) || (st == ST_GAP);
  assign done    = (st == ST_DONE);
  assign error   = (st == ST_ERR);

endmodule

// File: tb/tb_coin_payout_fsm.sv
// Directed self-checking bench for coin_payout_fsm (TIMEOUT=8, GAP_CYCLES=4).
module tb_coin_payout_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] amount = '0;
  logic       hopper_ack = 1'b0;
  logic       empty5 = 1'b0;
  logic       empty10 = 1'b0;
  logic       eject5, eject10, busy, done, error;
  logic [3:0] remaining;
  logic [2:0] state;
`ifdef COIN_TALLY_EN
  logic [7:0] tally5, tally10;
`endif

  int n_cmp = 0;
  int n_err = 0;

  coin_payout_fsm #(.AMT_W(4), .TIMEOUT(8), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount),
    .hopper_ack(hopper_ack), .empty5(empty5), .empty10(empty10),
    .eject5(eject5), .eject10(eject10), .busy(busy), .done(done),
    .error(error), .remaining(remaining),
`ifdef COIN_TALLY_EN
    .tally5(tally5), .tally10(tally10),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [3:0] amt);
    start  = 1'b1;
    amount = amt;
    step();
    start  = 1'b0;
    amount = 4'hA;
  endtask

  // Entered on the first EJECT cycle; acks on the third and runs through GAP to the next decision.
  task automatic serve(input string tag, input logic is10, input logic [3:0] rem_after);
    chk({tag, "_ej10"}, 16'(eject10), 16'(is10));
    chk({tag, "_ej5"},  16'(eject5),  16'(!is10));
    step(); step();
    chk({tag, "_hold"}, 16'({eject10, eject5}), 16'({is10, !is10}));
    hopper_ack = 1'b1;
    step();
    hopper_ack = 1'b0;
    chk({tag, "_gap"}, 16'(state), 16'd3);
    chk({tag, "_rem"}, 16'(remaining), 16'(rem_after));
    chk({tag, "_ejoff"}, 16'({eject10, eject5}), 16'd0);
    repeat (4) step();
    chk({tag, "_sel"}, 16'(state), 16'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_rem",   16'(remaining), 16'd0);
    chk("rst_outs",  16'({eject5, eject10, busy, done, error}), 16'd0);
    rst = 1'b0;
    step();

    // ack while idle is ignored
    hopper_ack = 1'b1;
    step();
    hopper_ack = 1'b0;
    chk("idle_ack", 16'({state, remaining}), 16'd0);

    // full payout of 5: 10,10,5
    pulse_start(4'd5);
    chk("fp_sel", 16'(state), 16'd1);
    chk("fp_busy", 16'(busy), 16'd1);
    chk("fp_load", 16'(remaining), 16'd5);
    step();
    serve("fp1", 1'b1, 4'd3);
    serve("fp2", 1'b1, 4'd1);
    serve("fp3", 1'b0, 4'd0);
    chk("fp_done", 16'({done, error, busy}), 16'b100);
    chk("fp_dstate", 16'(state), 16'd4);
    step();
    chk("fp_idle", 16'({state, done}), 16'd0);

    // 10-hopper empty: three 5-unit coins
    empty10 = 1'b1;
    pulse_start(4'd3);
    step();
    serve("e10a", 1'b0, 4'd2);
    serve("e10b", 1'b0, 4'd1);
    serve("e10c", 1'b0, 4'd0);
    chk("e10_done", 16'(done), 16'd1);
    step();

    // both hoppers empty: ERR straight from SEL
    empty5 = 1'b1;
    pulse_start(4'd2);
    chk("cp_sel", 16'(state), 16'd1);
    step();
    chk("cp_err", 16'({state, error}), 16'({3'd5, 1'b1}));
    chk("cp_rem", 16'(remaining), 16'd2);
    chk("cp_noej", 16'({eject5, eject10, busy}), 16'd0);
    step();
    chk("cp_stay", 16'(state), 16'd5);

    // timeout: no ack, eject5 high exactly TIMEOUT cycles
    empty5 = 1'b0;
    empty10 = 1'b0;
    pulse_start(4'd1);
    chk("to_sel", 16'({state, error}), 16'({3'd1, 1'b0}));
    chk("to_load", 16'(remaining), 16'd1);
    step();
    n = 0;
    while (eject5 && n < 20) begin
      n++;
      step();
    end
    chk("to_len", 16'(n), 16'd8);
    chk("to_err", 16'({state, error}), 16'({3'd5, 1'b1}));
    chk("to_rem", 16'(remaining), 16'd1);
    pulse_start(4'd2);
    chk("rc_sel", 16'({state, error, remaining}), 16'({3'd1, 1'b0, 4'd2}));
    step();
    serve("rc", 1'b1, 4'd0);
    chk("rc_done", 16'(done), 16'd1);
    step();

    // zero amount: done in the cycle after edge N+1
    pulse_start(4'd0);
    chk("z_sel", 16'(state), 16'd1);
    step();
    chk("z_done", 16'({state, done}), 16'({3'd4, 1'b1}));
    step();
    chk("z_idle", 16'(done), 16'd0);

    // start during GAP is ignored
    pulse_start(4'd3);
    step();
    chk("g_ej10", 16'(eject10), 16'd1);
    hopper_ack = 1'b1;
    step();
    hopper_ack = 1'b0;
    start  = 1'b1;
    amount = 4'd15;
    step();
    start  = 1'b0;
    chk("g_ign", 16'({state, remaining}), 16'({3'd3, 4'd1}));
    repeat (3) step();
    chk("g_sel", 16'(state), 16'd1);
    step();
    serve("g5", 1'b0, 4'd0);
    chk("g_done", 16'(done), 16'd1);
    step();

    // async reset mid-handshake
    pulse_start(4'd4);
    step();
    chk("ar_ej10", 16'(eject10), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_outs", 16'({eject10, eject5, busy}), 16'd0);
    chk("ar_rem", 16'({state, remaining}), 16'd0);
    #1 rst = 1'b0;
    step();
    chk("ar_idle", 16'(state), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/coin_payout_fsm.md
Name: coin_payout_fsm

Overview:
Change and refund dispenser for the vending datapath, paying money out where the credit FSM takes money in. A start pulse with an amount, in 5-unit steps, triggers a sequence of coin ejections on two hoppers (5-unit and 10-unit coins). Each ejection uses a request/acknowledge handshake with the hopper. The block reports progress, completion and failure (hopper empty or no acknowledge) to the top-level controller.

Parameters:
AMT_W, 4, width of amount in 5-unit steps (max payout 15*5 = 75)
TIMEOUT, 1000, max cycles in EJECT waiting for hopper_ack before error
GAP_CYCLES, 4, idle cycles between consecutive ejections (hopper settle time); must be >= 1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  1-cycle pulse; begin payout of amount
amount  in  AMT_W  payout in 5-unit steps; sampled on the start edge
hopper_ack  in  1  hopper confirms the requested coin was ejected
empty5  in  1  5-unit hopper empty
empty10  in  1  10-unit hopper empty
eject5  out  1  request one 5-unit coin; held until ack
eject10  out  1  request one 10-unit coin; held until ack
busy  out  1  payout in progress (SEL, EJECT, GAP)
done  out  1  1-cycle pulse; payout complete
error  out  1  high while in ERR
remaining  out  AMT_W  units still owed
state  out  3  current state encoding (debug)

Behaviour:
- Reset values: state=IDLE; remaining=0; counters=0; eject5, eject10, busy, done, error all 0. Async reset drops eject lines immediately, including mid-handshake.
- States: IDLE=0, SEL=1, EJECT=2, GAP=3, DONE=4, ERR=5. All outputs are Moore, decoded from registered state plus the latched coin_sel flag.
- IDLE: start=1 -> remaining<=amount, go to SEL. Otherwise stay.
- SEL: choose the coin and latch coin_sel:
  - remaining==0 -> DONE.
  - remaining>=2 and !empty10 -> coin_sel=10, EJECT.
  - else remaining>=1 and !empty5 -> coin_sel=5, EJECT.
  - else -> ERR.
- EJECT: eject10 or eject5 high per coin_sel. Timeout counter counts up from 0 on entry.
  - hopper_ack=1 -> remaining -= 2 (coin 10) or 1 (coin 5); counter clears; go to GAP.
  - counter reaches TIMEOUT-1 without ack -> ERR; remaining unchanged.
  - Ack in the same cycle as expiry: ack wins.
- GAP: stay exactly GAP_CYCLES cycles, then SEL. Eject lines low.
- DONE: done=1 for one cycle, then IDLE.
- ERR: error=1; remaining holds the unpaid amount. start=1 -> load the new amount, go to SEL (error drops). Otherwise stay.
- Latency:
  - start sampled at edge N -> SEL after N, EJECT visible after edge N+1.
  - amount=0 -> done high in the cycle after edge N+1.
- Ignored inputs:
  - start in SEL, EJECT, GAP or DONE is ignored; amount is not resampled.
  - hopper_ack outside EJECT is ignored.
- Hopper empty flags are evaluated only in SEL. A flag change during EJECT has no effect on the current coin.
- Never decrement below zero. The SEL rules guarantee remaining>=2 before paying a 10-unit coin.

Optional Feature:
COIN_TALLY_EN:
- Defined: adds outputs tally5[7:0] and tally10[7:0], counting acknowledged ejections since reset. Counters saturate at 255 and are cleared only by rst.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package vend_pkg: state encodings (ST_IDLE..ST_ERR), COIN5_UNITS=1, COIN10_UNITS=2. Shared with the credit-side FSM so coin units match.
- Sub-module payout_timer: loadable up-counter with clear, enable and terminal flag. Instantiated twice: EJECT timeout (TIMEOUT) and GAP wait (GAP_CYCLES).

Test Plan:
- Full payout: amount=5, both hoppers full, ack 3 cycles after each eject -> eject10, eject10, eject5 in order; remaining 5->3->1->0; one done pulse; error=0.
- 10-hopper empty: amount=3, empty10=1 -> three eject5 requests, no eject10, done pulse.
- Cannot pay: amount=2, empty10=1, empty5=1 -> ERR one cycle after SEL; error=1; remaining=2; no eject.
- Timeout: TIMEOUT=8, amount=1, no ack -> eject5 high exactly 8 cycles, then error=1, remaining=1. Next start with amount=2 -> recovers and pays one 10-unit coin.
- Zero amount and ignored start: amount=0 -> done in the cycle after edge N+1. A start pulse during GAP has no effect on remaining or sequence.
- Reset mid-eject: assert rst while eject10=1 -> eject10, busy and remaining go to 0 immediately (before the next clock edge).
